mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning number of 32-bit words in the internal memory array (power of two, >= 4).
REQ-002 SHALL have parameter LAT, default 2, meaning memory access latency in cycles (integer >= 1).
REQ-003 CLK  input  1  single clock, all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 imemREN  input  1  instruction fetch request.
REQ-006 imemaddr  input  32  instruction byte address.
REQ-007 dmemREN  input  1  data read request.
REQ-008 dmemWEN  input  1  data write request.
REQ-009 dmemaddr  input  32  data byte address.
REQ-010 dmemstore  input  32  data write value.
REQ-011 ihit  output  1  one-cycle pulse, instruction fetch complete.
REQ-012 dhit  output  1  one-cycle pulse, data read or write complete.
REQ-013 imemload  output  32  fetched instruction word.
REQ-014 dmemload  output  32  data read word.

Function
REQ-015 SHALL implement states IDLE, IBUSY, DBUSY, HIT, each held in a registered state variable.
REQ-016 SHALL sample requests only in IDLE; requests present in BUSY or HIT are ignored, not queued.
REQ-017 In IDLE, only data pending (dmemREN|dmemWEN) -> DBUSY; only imemREN -> IBUSY; none -> stay IDLE.
REQ-018 In IDLE, both pending: data wins unless last_d=1, in which case instruction wins (alternating fairness).
REQ-019 SHALL set last_d to 1 on accepting a data request and to 0 on accepting an instruction request.
REQ-020 On acceptance SHALL latch kind (I/D-read/D-write), word index addr[log2(DEPTH)+1:2] and dmemstore; upper and low two address bits ignored.
REQ-021 dmemREN and dmemWEN both high SHALL be serviced as a write only; dmemload unchanged.
REQ-022 Request accepted at edge k -> BUSY state with cycle counter cleared; counter increments each cycle; transition BUSY -> HIT at edge k+LAT.
REQ-023 At edge k+LAT, read SHALL register mem[index] into imemload or dmemload; write SHALL commit latched data to mem[index].
REQ-024 In HIT, SHALL assert exactly one of ihit/dhit per latched kind for exactly one cycle (k+LAT to k+LAT+1), then go IDLE.
REQ-025 Requester deasserting or changing inputs during BUSY SHALL NOT alter the in-flight access (latched values used).
REQ-026 Read-after-write to same index SHALL return the written value (write commits before later read's sampling edge).
REQ-027 imemload/dmemload SHALL hold last value until next completed read of same kind.
REQ-028 ihit and dhit SHALL never be high in the same cycle; both low outside HIT.
REQ-029 Minimum spacing between accepted requests SHALL be LAT+2 cycles.

Reset
REQ-030 RST high at an edge SHALL force state IDLE, counter 0, last_d 0, ihit 0, dhit 0, imemload 0, dmemload 0, regardless of state.
REQ-031 RST during BUSY SHALL abort the access: no write commit, no hit pulse.
REQ-032 Memory array contents SHALL NOT be affected by RST.

Verification
REQ-033 LAT=2: dmemWEN=1, addr 0x10, store 0xDEADBEEF at edge 0 -> dhit high cycle 2-3 only; then dmemREN addr 0x10 -> dhit with dmemload=0xDEADBEEF.
REQ-034 imemREN and dmemREN both high continuously from reset -> accepted order D, I, D, I; ihit/dhit alternate, never coincident.
REQ-035 Data read accepted then dmemREN dropped and dmemaddr changed next cycle -> dhit still at k+LAT, data from original address.
REQ-036 Write accepted, RST asserted at k+1 -> no dhit; later read of that address returns prior contents.
REQ-037 dmemREN=dmemWEN=1, addr 0x20, store 0x5 -> write performed, dmemload unchanged, later read of 0x20 returns 0x5.
REQ-038 Address 0x10 vs 0x10+4*DEPTH+3 -> both access same word (aliasing/low-bit masking).

Source files
------------

// File: rtl/mem_responder.sv
// Single-port word memory answering instruction and data requests one at a time.
// The fixed access latency is LAT cycles, and each completed access gives a one-cycle hit pulse.
module mem_responder #(
  parameter int DEPTH = 256,
  parameter int LAT   = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] imemload,
  output logic [31:0] dmemload
);

  // state | meaning
  // IDLE  | sampling requests, data/instruction arbitration by last_d
  // IBUSY | instruction fetch in flight, counting latency
  // DBUSY | data read or write in flight, counting latency
  // HIT   | access complete, hit pulse for the latched kind
  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, HIT} state_t;
  typedef enum logic [1:0] {K_I, K_DR, K_DW} kind_t;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LAT - 1);

  state_t          state, next;
  kind_t           kind;
  logic [AW-1:0]   idx;
  logic [31:0]     wdata;
  logic [CW-1:0]   cnt;
  logic            last_d;
  logic            acc_i, acc_d, done, d_pend;
  logic [31:0]     mem [DEPTH];

  // Address bits outside the word index are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^{imemaddr[31:AW+2], imemaddr[1:0], dmemaddr[31:AW+2], dmemaddr[1:0]};

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next   = state;
    acc_i  = 1'b0;
    acc_d  = 1'b0;
    done   = 1'b0;
    d_pend = dmemREN | dmemWEN;
    case (state)
      IDLE: begin
        if (d_pend && (!imemREN || !last_d)) begin
          acc_d = 1'b1;
          next  = DBUSY;
        end else if (imemREN) begin
          acc_i = 1'b1;
          next  = IBUSY;
        end
      end
      IBUSY, DBUSY: begin
        if (cnt == CNT_LAST) begin
          done = 1'b1;
          next = HIT;
        end
      end
      HIT:     next = IDLE;
      default: next = IDLE;
    endcase
  end

  assign ihit = (state == HIT) && (kind == K_I);
  assign dhit = (state == HIT) && (kind != K_I);

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt      <= '0;
      last_d   <= 1'b0;
      imemload <= '0;
      dmemload <= '0;
    end else begin
      if (acc_d) begin
        last_d <= 1'b1;
        cnt    <= '0;
      end else if (acc_i) begin
        last_d <= 1'b0;
        cnt    <= '0;
      end else if ((state == IBUSY || state == DBUSY) && !done) begin
        cnt <= cnt + 1'b1;
      end
      if (done && kind == K_I)  imemload <= mem[idx];
      if (done && kind == K_DR) dmemload <= mem[idx];
    end
  end

  // Request fields are captured at acceptance so the requester may move on.
  always_ff @(posedge CLK) begin
    if (acc_d) begin
      kind  <= dmemWEN ? K_DW : K_DR;
      idx   <= dmemaddr[AW+1:2];
      wdata <= dmemstore;
    end else if (acc_i) begin
      kind <= K_I;
      idx  <= imemaddr[AW+1:2];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && done && kind == K_DW) mem[idx] <= wdata;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with LAT=2 and DEPTH=256.
// Expected values are hand-computed, and each step is checked with an immediate assertion.
module tb_mem_responder;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        ihit;
  logic        dhit;
  logic [31:0] imemload;
  logic [31:0] dmemload;

  int total = 0;
  int passes = 0;

  mem_responder #(.DEPTH(256), .LAT(2)) dut (
    .CLK(CLK), .RST(RST),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .ihit(ihit), .dhit(dhit), .imemload(imemload), .dmemload(dmemload)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic clr;
    imemREN   = 1'b0;
    dmemREN   = 1'b0;
    dmemWEN   = 1'b0;
    imemaddr  = '0;
    dmemaddr  = '0;
    dmemstore = '0;
  endtask

  // One data access: accept, two busy edges, HIT, back to IDLE.
  task automatic data_op(input logic ren, input logic wen, input logic [31:0] addr,
                         input logic [31:0] store, input string tag);
    dmemREN = ren; dmemWEN = wen; dmemaddr = addr; dmemstore = store;
    tick;
    clr;
    tick;
    chk({tag, "_busy"}, {31'b0, dhit}, 32'd0);
    tick;
    chk({tag, "_dhit"}, {31'b0, dhit}, 32'd1);
    chk({tag, "_ihit"}, {31'b0, ihit}, 32'd0);
    tick;
    chk({tag, "_done"}, {31'b0, dhit}, 32'd0);
  endtask

  initial begin
    clr;
    RST = 1'b1;
    tick;
    tick;
    chk("rst_ihit", {31'b0, ihit}, 32'd0);
    chk("rst_dhit", {31'b0, dhit}, 32'd0);
    chk("rst_iload", imemload, 32'd0);
    chk("rst_dload", dmemload, 32'd0);
    RST = 1'b0;

    // Write 0x10, observing dhit edge by edge.
    dmemWEN = 1'b1; dmemaddr = 32'h10; dmemstore = 32'hDEADBEEF;
    tick;
    clr;
    chk("wr_e0", {31'b0, dhit}, 32'd0);
    tick;
    chk("wr_e1", {31'b0, dhit}, 32'd0);
    tick;
    chk("wr_e2", {31'b0, dhit}, 32'd1);
    tick;
    chk("wr_e3", {31'b0, dhit}, 32'd0);
    data_op(1'b1, 1'b0, 32'h10, 32'h0, "rd10");
    chk("rd10_val", dmemload, 32'hDEADBEEF);
    data_op(1'b0, 1'b1, 32'h40, 32'h12345678, "wr40");

    // Both requesters continuously active from reset: D, I, D, I.
    RST = 1'b1;
    tick;
    RST = 1'b0;
    chk("rst2_dload", dmemload, 32'd0);
    imemREN = 1'b1; imemaddr = 32'h40; dmemREN = 1'b1; dmemaddr = 32'h10;
    for (int n = 0; n < 16; n++) begin
      logic dexp, iexp;
      tick;
      dexp = (n % 4 == 2) && ((n / 4) % 2 == 0);
      iexp = (n % 4 == 2) && ((n / 4) % 2 == 1);
      chk($sformatf("arb_d%0d", n), {31'b0, dhit}, {31'b0, dexp});
      chk($sformatf("arb_i%0d", n), {31'b0, ihit}, {31'b0, iexp});
    end
    clr;
    chk("arb_iload", imemload, 32'h12345678);
    chk("arb_dload", dmemload, 32'hDEADBEEF);

    // Requester changes address after acceptance.
    data_op(1'b1, 1'b0, 32'h40, 32'h0, "rd40");
    chk("rd40_val", dmemload, 32'h12345678);
    dmemREN = 1'b1; dmemaddr = 32'h10;
    tick;
    dmemREN = 1'b0; dmemaddr = 32'h40;
    tick;
    chk("chg_busy", {31'b0, dhit}, 32'd0);
    tick;
    chk("chg_dhit", {31'b0, dhit}, 32'd1);
    chk("chg_val", dmemload, 32'hDEADBEEF);
    tick;
    clr;

    // Reset during a write aborts it.
    data_op(1'b0, 1'b1, 32'h30, 32'hAAAA5555, "wr30");
    dmemWEN = 1'b1; dmemaddr = 32'h30; dmemstore = 32'h11111111;
    tick;
    clr;
    RST = 1'b1;
    tick;
    RST = 1'b0;
    chk("abort_dhit0", {31'b0, dhit}, 32'd0);
    chk("abort_dload", dmemload, 32'd0);
    tick;
    chk("abort_dhit1", {31'b0, dhit}, 32'd0);
    tick;
    chk("abort_dhit2", {31'b0, dhit}, 32'd0);
    data_op(1'b1, 1'b0, 32'h30, 32'h0, "rd30");
    chk("rd30_val", dmemload, 32'hAAAA5555);

    // Read and write together is a write only.
    data_op(1'b1, 1'b1, 32'h20, 32'h5, "rw20");
    chk("rw_keep", dmemload, 32'hAAAA5555);
    data_op(1'b1, 1'b0, 32'h20, 32'h0, "rd20");
    chk("rd20_val", dmemload, 32'h5);

    // Aliasing through upper and low address bits.
    data_op(1'b1, 1'b0, 32'h10 + 32'd4 * 32'd256 + 32'd3, 32'h0, "alias_rd");
    chk("alias_rd_val", dmemload, 32'hDEADBEEF);
    data_op(1'b0, 1'b1, 32'hFFFFF013, 32'hCAFEF00D, "alias_wr");
    data_op(1'b1, 1'b0, 32'h10, 32'h0, "alias_chk");
    chk("alias_chk_val", dmemload, 32'hCAFEF00D);

    // Standalone instruction fetch.
    imemREN = 1'b1; imemaddr = 32'h20;
    tick;
    clr;
    tick;
    chk("if_busy", {31'b0, ihit}, 32'd0);
    tick;
    chk("if_ihit", {31'b0, ihit}, 32'd1);
    chk("if_dhit", {31'b0, dhit}, 32'd0);
    chk("if_val", imemload, 32'h5);
    tick;
    chk("if_done", {31'b0, ihit}, 32'd0);

    // A fetch raised only while busy is dropped, not queued.
    dmemREN = 1'b1; dmemaddr = 32'h30;
    tick;
    clr;
    imemREN = 1'b1; imemaddr = 32'h10;
    tick;
    tick;
    chk("ign_dhit", {31'b0, dhit}, 32'd1);
    imemREN = 1'b0;
    tick;
    tick;
    tick;
    tick;
    chk("ign_ihit", {31'b0, ihit}, 32'd0);
    chk("ign_iload", imemload, 32'h5);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
